// File: rtl/fifo_sync_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_sync_param                                                            |
// | Parametrised single-clock FIFO with occupancy count, threshold flags,      |
// | sticky overflow/underflow errors, synchronous flush and read-valid strobe. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fifo_sync_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              clear,
  input  logic              write,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int            c_DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] c_DEPTH_CNT = (ADDR_W+1)'(c_DEPTH);
  localparam logic [ADDR_W:0] c_AF_CNT    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] c_AE_CNT    = (ADDR_W+1)'(AE_LEVEL);
  localparam logic [ADDR_W:0] c_ONE       = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] r_mem [c_DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_data_out;
  logic              r_data_valid;
  logic              r_overflow;
  logic              r_underflow;

  logic w_full;
  logic w_empty;
  logic w_active;
  logic w_wr_acc;
  logic w_rd_acc;

  assign w_full   = (r_count == c_DEPTH_CNT);
  assign w_empty  = (r_count == '0);
  // Flush takes priority: nothing is accepted in a clear cycle.
  assign w_active = en & ~clear;
  assign w_wr_acc = w_active & write & ~w_full;
  assign w_rd_acc = w_active & read & ~w_empty;

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else if (clear) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_data_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else if (en) begin
      r_data_valid <= w_rd_acc;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_data_out <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + c_ONE;
        2'b01:   r_count <= r_count - c_ONE;
        default: r_count <= r_count;
      endcase
      if (write && w_full) begin
        r_overflow <= 1'b1;
      end
      if (read && w_empty) begin
        r_underflow <= 1'b1;
      end
    end else begin
      r_data_valid <= 1'b0;
    end
  end

  assign data_out     = r_data_out;
  assign data_valid   = r_data_valid;
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_full  = (r_count >= c_AF_CNT);
  assign almost_empty = (r_count <= c_AE_CNT);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fifo_sync_param                                                         |
// | Directed and random stimulus against a queue-based FIFO reference model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fifo_sync_param;

  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic       clear = 1'b0;
  logic       write = 1'b0;
  logic [7:0] data_in = '0;
  logic       read = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  fifo_sync_param #(.DATA_W(8), .ADDR_W(3), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .clear(clear),
    .write(write), .data_in(data_in), .read(read),
    .data_out(data_out), .data_valid(data_valid),
    .empty(empty), .full(full), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] q[$];
  logic [7:0] m_dout;
  logic       m_valid;
  logic       m_ovf;
  logic       m_unf;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"},        32'(count),        32'(q.size()));
    chk({tag, ".empty"},        32'(empty),        32'(q.size() == 0));
    chk({tag, ".full"},         32'(full),         32'(q.size() == DEPTH));
    chk({tag, ".almost_full"},  32'(almost_full),  32'(q.size() >= AF));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(q.size() <= AE));
    chk({tag, ".data_valid"},   32'(data_valid),   32'(m_valid));
    chk({tag, ".data_out"},     32'(data_out),     32'(m_dout));
    chk({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
    chk({tag, ".underflow"},    32'(underflow),    32'(m_unf));
  endtask

  task automatic model_reset();
    q.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  // One clock: drive at negedge, advance model from pre-edge state, check after edge
  task automatic step(input string tag, input logic w, input logic r,
                      input logic [7:0] d, input logic e = 1'b1, input logic c = 1'b0);
    bit was_full, was_empty;
    @(negedge clk);
    write = w; read = r; data_in = d; en = e; clear = c;
    if (c) begin
      q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b0;
    end else if (e) begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      m_valid = 1'b0;
      if (w && was_full)  m_ovf = 1'b1;
      if (r && was_empty) m_unf = 1'b1;
      if (r && !was_empty) begin
        m_dout  = q.pop_front();
        m_valid = 1'b1;
      end
      if (w && !was_full) q.push_back(d);
    end else begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    step("idle", 1'b0, 1'b0, 8'h00);
  endtask

  task automatic fill_to(input int n);
    while (q.size() < n) step("fill", 1'b1, 1'b0, 8'($urandom_range(0, 255)));
    while (q.size() > n) step("drain", 1'b0, 1'b1, 8'h00);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset_n = 1'b1;
    en = 1'b1;

    // Fill with 0x10..0x17, then one write too many
    for (int i = 0; i < 8; i++) step("wr_fill", 1'b1, 1'b0, 8'(8'h10 + i));
    step("wr_over", 1'b1, 1'b0, 8'hEE);

    // Drain all, then one read too many
    for (int i = 0; i < 8; i++) step("rd_drain", 1'b0, 1'b1, 8'h00);
    step("rd_under", 1'b0, 1'b1, 8'h00);
    idle();
    step("clear1", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Pointer wrap
    for (int i = 0; i < 5; i++) step("wrap_w5", 1'b1, 1'b0, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 5; i++) step("wrap_r5", 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 8; i++) step("wrap_w8", 1'b1, 1'b0, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 8; i++) step("wrap_r8", 1'b0, 1'b1, 8'h00);

    // Simultaneous read/write: mid-range, full, empty
    fill_to(3);
    for (int i = 0; i < 10; i++) step("rw_mid", 1'b1, 1'b1, 8'($urandom_range(0, 255)));
    fill_to(8);
    step("rw_full", 1'b1, 1'b1, 8'hA5);
    step("clear2", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    step("rw_empty", 1'b1, 1'b1, 8'h5A);
    step("rd_after_empty", 1'b0, 1'b1, 8'h00);

    // Enable low holds everything; clear still acts
    step("clear3", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    fill_to(2);
    for (int i = 0; i < 4; i++) step("en_low", 1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
    step("clear_en_low", 1'b1, 1'b1, 8'h33, 1'b0, 1'b1);
    step("clear_with_rw", 1'b1, 1'b1, 8'h44, 1'b1, 1'b1);

    // Asynchronous reset mid-burst at count 5
    fill_to(5);
    step("pre_rst_rd", 1'b0, 1'b1, 8'h00);
    step("pre_rst_wr", 1'b1, 1'b0, 8'h77);
    @(negedge clk);
    write = 1'b1; data_in = 8'h99;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    write = 1'b0;
    reset_n = 1'b1;
    step("post_rst_wr", 1'b1, 1'b0, 8'hC3);
    step("post_rst_rd", 1'b0, 1'b1, 8'h00);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 49) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised synchronous FIFO; next generation of the 8x8 baseband byte FIFO.
- Buffers words between the RFID decoder/encoder stages and the tag controller.
- Adds configurable width and depth, true full-depth occupancy, and an exposed count.
- Adds almost-full/almost-empty thresholds, sticky overflow/underflow error flags, synchronous flush, and a registered read-data valid strobe.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 3, pointer width; DEPTH = 2**ADDR_W words
AF_LEVEL, 6, almost_full asserted when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 1, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  in  1  single clock, all logic on posedge
reset_n  in  1  asynchronous active-low reset
en  in  1  block enable; when low, read/write are ignored and all state holds
clear  in  1  synchronous flush; priority over en
write  in  1  write request
data_in  in  DATA_W  write data
read  in  1  read request
data_out  out  DATA_W  registered read data
data_valid  out  1  one-cycle pulse; data_out updated this cycle
empty  out  1  count == 0
full  out  1  count == DEPTH
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (asynchronous, reset_n low): wr_ptr, rd_ptr, count = 0; data_out = 0; data_valid = 0; overflow = underflow = 0. Hence empty = 1, almost_empty = 1, full = 0, almost_full = 0. Memory contents are not reset and are don't-care.
- Status flags are combinational from the count register and change in the cycle after the accepting edge.
- Accept rules (evaluated at posedge with en = 1, clear = 0):
  - wr_acc = write & !full.
  - rd_acc = read & !empty.
  - Both flags are based on pre-edge count; no same-cycle pass-through.
- Write: mem[wr_ptr] <= data_in; wr_ptr increments modulo DEPTH (natural binary wrap).
- Read: data_out <= mem[rd_ptr]; rd_ptr increments modulo DEPTH; data_valid = 1 in the next cycle only. Read latency is 1 clock from the accepting edge.
- When no read is accepted, data_out holds its last value and data_valid = 0.
- Count update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both or neither are accepted.
- Simultaneous read and write:
  - Mid-range: both accepted; count constant.
  - When full: read accepted, write rejected, overflow set.
  - When empty: write accepted, read rejected, underflow set. The written word becomes readable the next cycle.
- Error flags:
  - overflow <= 1 on write & full.
  - underflow <= 1 on read & empty.
  - Both are sticky and cleared only by reset_n or clear.
- en = 0: no accepts, no flag updates, data_valid = 0, all registers hold. clear still acts.
- clear = 1 (synchronous): pointers, count, overflow, underflow, data_valid = 0. data_out holds. Any read/write in the same cycle is ignored.
- Reset mid-operation: immediate return to the reset state; no partial write.
- Memory: register array or inferred RAM with synchronous write and registered read; one write and one read port.
- Pointer and count arithmetic are unsigned. The count is ADDR_W+1 bits so that DEPTH is representable.

Test Plan:
- Reset, then write 8 words 0x10..0x17 with defaults → full = 1 and count = 8 after the 8th edge; almost_full rises after the 6th; a 9th write sets overflow = 1 and count stays 8.
- Read 8 words back → data_out = 0x10..0x17 in order, each with a data_valid pulse one cycle after its read; empty = 1 after the 8th; a 9th read sets underflow = 1 with data_valid = 0.
- Wrap-around: write 5, read 5, write 8, read 8 → order is preserved across the pointer wrap and count returns to 0.
- Simultaneous read and write at count = 3 for 10 cycles → count stays 3 and outputs are a FIFO-ordered stream. The same stimulus at full causes only the read to be accepted (count = 7, overflow = 1). At empty, only the write is accepted (count = 1, underflow = 1).
- With en = 0, drive write and read for 4 cycles at count = 2 → no change to count, data_out, or flags. Then assert clear → count = 0 and overflow/underflow = 0.
- Assert reset_n low asynchronously mid-burst at count = 5 → empty = 1, data_out = 0, and flags = 0 immediately. A write after release lands at address 0 and reads back correctly.
